// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Posted-store FIFO sitting between the MEM-stage store path and the data
//   memory write port. Stores are accepted in one cycle and drained oldest
//   first, one per cycle. Loads probe the buffer combinationally so that a
//   load never reads a stale word from data memory.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   st_valid/addr/data/be   store request from MEM stage
//   st_ready                buffer can accept a store this cycle
//   drain_en                data memory write port free this cycle
//   dm_we/addr/din/be       write to data memory (head entry)
//   ld_addr                 load address probe
//   ld_hit/ld_data          youngest match is a full word, forwarded data
//   ld_stall                youngest match is a partial word
//   empty, count            occupancy
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_be,
    output logic             st_ready,
    input  logic             drain_en,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [31:0]      dm_din,
    output logic [3:0]       dm_be,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic [31:0]      ld_data,
    output logic             ld_stall,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [29:0]      e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [3:0]       e_be   [DEPTH];
    logic [DEPTH-1:0] e_valid;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    // Low address bits select a byte lane only; the buffer works on words.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready = (count < CNT_FULL);
    assign empty    = (count == '0);
    assign push     = st_valid & st_ready;
    assign dm_we    = !empty & drain_en;
    assign pop      = dm_we;

    // Head contents are gated by !empty so the write port reads zero after
    // reset without having to clear the storage array.
    assign dm_addr = empty ? 32'h0 : {e_addr[head], 2'b00};
    assign dm_din  = empty ? 32'h0 : e_data[head];
    assign dm_be   = empty ? 4'h0  : e_be[head];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
        end else begin
            if (push) begin
                e_valid[tail] <= 1'b1;
                tail          <= tail + PTR_ONE;
            end
            // push and pop cannot target the same slot: that needs the buffer
            // to be both full (push blocked) and empty (pop blocked).
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by e_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            e_addr[tail] <= st_addr[31:2];
            e_data[tail] <= st_data;
            e_be[tail]   <= st_be;
        end
    end

    // Walk entries oldest to youngest; the last match wins, giving the entry
    // closest to tail. A store being pushed this cycle is not yet stored and
    // so cannot match; the entry being popped still can.
    logic             fwd_found;
    logic [PTR_W-1:0] fwd_sel;
    logic [PTR_W-1:0] fwd_idx;

    always_comb begin
        fwd_found = 1'b0;
        fwd_sel   = '0;
        fwd_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if (e_valid[fwd_idx] && (e_addr[fwd_idx] == ld_addr[31:2])) begin
                fwd_found = 1'b1;
                fwd_sel   = fwd_idx;
            end
        end
    end

    assign ld_hit   = fwd_found && (e_be[fwd_sel] == 4'b1111);
    assign ld_stall = fwd_found && (e_be[fwd_sel] != 4'b1111);
    assign ld_data  = ld_hit ? e_data[fwd_sel] : 32'h0;

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        st_ready;
    logic        drain_en;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [3:0]  dm_be;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        empty;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ready(st_ready), .drain_en(drain_en),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_be(dm_be),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted stores, oldest at index 0.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            int  n;
            ent_t e;
            n = q.size();
            if (n > 0 && drain_en) void'(q.pop_front());
            if (st_valid && n < DEPTH) begin
                e.addr = st_addr;
                e.data = st_data;
                e.be   = st_be;
                q.push_back(e);
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            logic        e_we;
            logic        found;
            ent_t        m;
            int          n;
            n     = q.size();
            e_we  = (n > 0) && drain_en;
            found = 1'b0;
            m.addr = '0; m.data = '0; m.be = '0;
            for (int i = n - 1; i >= 0; i--) begin
                if (!found && q[i].addr[31:2] == ld_addr[31:2]) begin
                    found = 1'b1;
                    m     = q[i];
                end
            end
            chk("count",    32'(count),    32'(n));
            chk("empty",    32'(empty),    32'(n == 0));
            chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
            chk("dm_we",    32'(dm_we),    32'(e_we));
            if (e_we) begin
                chk("dm_addr", dm_addr,      {q[0].addr[31:2], 2'b00});
                chk("dm_din",  dm_din,       q[0].data);
                chk("dm_be",   32'(dm_be),   32'(q[0].be));
            end
            chk("ld_hit",   32'(ld_hit),   32'(found && m.be == 4'hF));
            chk("ld_stall", 32'(ld_stall), 32'(found && m.be != 4'hF));
            chk("ld_data",  ld_data,       (found && m.be == 4'hF) ? m.data : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        st_valid = v; st_addr = a; st_data = d; st_be = b;
    endtask

    task automatic drain_all();
        st_valid = 1'b0;
        drain_en = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        set_st(1'b0, 32'h0, 32'h0, 4'h0);
        drain_en = 1'b0;
        ld_addr  = 32'h0;
        #12;
        chk("rst st_ready", 32'(st_ready), 32'd1);
        chk("rst empty",    32'(empty),    32'd1);
        chk("rst count",    32'(count),    32'd0);
        chk("rst dm_we",    32'(dm_we),    32'd0);
        chk("rst ld_hit",   32'(ld_hit),   32'd0);
        chk("rst ld_stall", 32'(ld_stall), 32'd0);
        chk("rst ld_data",  ld_data,       32'd0);
        chk("rst dm_addr",  dm_addr,       32'd0);
        chk("rst dm_din",   dm_din,        32'd0);
        chk("rst dm_be",    32'(dm_be),    32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: single store, latency one, then empty
        set_st(1'b1, 32'h10, 32'h11111111, 4'hF);
        drain_en = 1'b1;
        tick();
        st_valid = 1'b0;
        #1;
        chk("t1 dm_we",   32'(dm_we), 32'd1);
        chk("t1 dm_addr", dm_addr,    32'h10);
        chk("t1 dm_din",  dm_din,     32'h11111111);
        tick();
        chk("t1 empty",   32'(empty), 32'd1);

        // 2: fill, drop fifth, drain in order
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_st(1'b1, 32'h100 + 32'(4 * k), 32'hD0 + 32'(k), 4'hF);
            tick();
        end
        chk("t2 count",    32'(count),    32'd4);
        chk("t2 st_ready", 32'(st_ready), 32'd0);
        set_st(1'b1, 32'h1F0, 32'hDEAD, 4'hF);
        tick();
        chk("t2 drop count", 32'(count), 32'd4);
        st_valid = 1'b0;
        drain_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2 order addr", dm_addr, 32'h100 + 32'(4 * k));
            chk("t2 order data", dm_din,  32'hD0 + 32'(k));
            tick();
        end
        chk("t2 final count", 32'(count), 32'd0);

        // 3: youngest full-word match forwards
        drain_en = 1'b0;
        set_st(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF); tick();
        set_st(1'b1, 32'h20, 32'hBBBBBBBB, 4'hF); tick();
        st_valid = 1'b0;
        ld_addr  = 32'h22;
        #1;
        chk("t3 ld_hit",  32'(ld_hit), 32'd1);
        chk("t3 ld_data", ld_data,     32'hBBBBBBBB);
        drain_all();

        // 4: partial match stalls until drained
        drain_en = 1'b0;
        set_st(1'b1, 32'h30, 32'h0000CCCC, 4'b0011); tick();
        st_valid = 1'b0;
        ld_addr  = 32'h30;
        #1;
        chk("t4 ld_stall", 32'(ld_stall), 32'd1);
        chk("t4 ld_hit",   32'(ld_hit),   32'd0);
        drain_en = 1'b1;
        tick();
        chk("t4 stall cleared", 32'(ld_stall), 32'd0);

        // 5: steady push+pop at count 2
        drain_en = 1'b0;
        set_st(1'b1, 32'h40, 32'h40, 4'hF); tick();
        set_st(1'b1, 32'h44, 32'h44, 4'hF); tick();
        drain_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_st(1'b1, 32'h48 + 32'(4 * k), 32'h48 + 32'(4 * k), 4'hF);
            #1;
            chk("t5 wr addr", dm_addr, 32'h40 + 32'(4 * k));
            tick();
            chk("t5 count", 32'(count), 32'd2);
        end
        drain_all();

        // 6: reset mid-drain discards pending stores immediately
        drain_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_st(1'b1, 32'h50 + 32'(4 * k), 32'h5 + 32'(k), 4'hF);
            tick();
        end
        st_valid = 1'b0;
        drain_en = 1'b1;
        #1;
        chk("t6 pre dm_we", 32'(dm_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6 rst dm_we", 32'(dm_we), 32'd0);
        chk("t6 rst count", 32'(count), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6 no write", 32'(dm_we), 32'd0);
            tick();
        end

        // Random traffic on a small address pool to exercise forwarding.
        for (int c = 0; c < 3000; c++) begin
            st_valid = ($urandom_range(0, 99) < 55);
            st_addr  = 32'h200 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            st_data  = $urandom;
            st_be    = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            drain_en = ($urandom_range(0, 99) < 45);
            ld_addr  = 32'h200 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
            tick();
        end

        st_valid = 1'b0;
        drain_en = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
